// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: data width default,
// 2-bit branch counter encodings, PC increment and the counter update rule.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_INCR      = 4;

  // 2-bit saturating direction counter encodings; bit 1 is the prediction.
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Move a direction counter one step toward the observed outcome,
  // holding at the strongly-taken / strongly-not-taken ends.
  function automatic logic [1:0] sat_cnt_update(input logic [1:0] cnt,
                                                input logic       taken);
    logic [1:0] res;
    if (taken) res = (cnt == ST)  ? ST  : cnt + 2'd1;
    else       res = (cnt == SNT) ? SNT : cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled events until the counter reaches its maximum value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor with a direct-mapped branch target buffer.
// Lookup is combinational from the fetch PC; resolution from ID trains the
// counters, allocates BTB entries on taken branches and repairs the global
// history after a mispredict.
//
// Interface timing: there is no back-pressure. The predictor accepts a lookup
// whenever lookup_valid_i is high and an update whenever upd_valid_i is high,
// both qualified by start_i; nothing is ever refused or stalled by this block.
module branch_predictor #(
  parameter int XLEN      = riscv_pkg::XLEN_DEFAULT,
  parameter int ENTRIES   = 64,  // power of two, at least 4
  parameter int HIST_BITS = 6,   // 1 .. log2(ENTRIES)
  parameter int TAG_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 lookup_valid_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 pred_taken_o,
  output logic [XLEN-1:0]      pred_target_o,
  output logic [HIST_BITS-1:0] ghr_o,
  input  logic                 upd_valid_i,
  input  logic [XLEN-1:0]      upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic [XLEN-1:0]      upd_target_i,
  input  logic [HIST_BITS-1:0] upd_hist_i,
  input  logic                 upd_mispredict_i,
  output logic [31:0]          stat_lookups_o,
  output logic [31:0]          stat_mispredicts_o
);

  import riscv_pkg::*;

  localparam int IDX = $clog2(ENTRIES);

  // Predictor state: direction counters, BTB arrays and global history.
  logic [1:0]           bht        [ENTRIES];
  logic [ENTRIES-1:0]   btb_valid;
  logic [TAG_BITS-1:0]  btb_tag    [ENTRIES];
  logic [XLEN-1:0]      btb_target [ENTRIES];
  logic [HIST_BITS-1:0] ghr;

  // Lookup side.
  logic [IDX-1:0]      bidx;
  logic [IDX-1:0]      gidx;
  logic [TAG_BITS-1:0] tag;
  logic                hit;

  // Update side.
  logic [IDX-1:0]      upd_bidx;
  logic [IDX-1:0]      upd_gidx;
  logic [TAG_BITS-1:0] upd_tag;

  // Qualified events.
  logic spec_shift;
  logic repair;
  logic upd_en;

  // PC bits outside the index and tag fields carry no information here.
  logic unused_upd_pc;

  // gshare hash: history is aligned to the top of the index so a short
  // history still perturbs the most significant index bits.
  function automatic logic [IDX-1:0] hash_idx(input logic [IDX-1:0]       b,
                                              input logic [HIST_BITS-1:0] h);
    return b ^ (IDX'(h) << (IDX - HIST_BITS));
  endfunction

  assign bidx     = pc_i[IDX+1:2];
  assign tag      = pc_i[IDX+TAG_BITS+1:IDX+2];
  assign gidx     = hash_idx(bidx, ghr);

  assign upd_bidx = upd_pc_i[IDX+1:2];
  assign upd_tag  = upd_pc_i[IDX+TAG_BITS+1:IDX+2];
  assign upd_gidx = hash_idx(upd_bidx, upd_hist_i);

  assign unused_upd_pc = ^{upd_pc_i[XLEN-1:IDX+TAG_BITS+2], upd_pc_i[1:0]};

  // Prediction reads the arrays as they stand before any update this cycle,
  // so a same-index write is only seen on the following cycle.
  always_comb begin
    hit           = btb_valid[bidx] && (btb_tag[bidx] == tag);
    pred_taken_o  = hit && bht[gidx][1];
    pred_target_o = pred_taken_o ? btb_target[bidx] : pc_i + XLEN'(PC_INCR);
    ghr_o         = ghr;
  end

  // A valid mispredict both repairs history and suppresses the speculative
  // shift; a mispredict flag without upd_valid_i has no effect at all.
  assign repair     = start_i && upd_valid_i && upd_mispredict_i;
  assign spec_shift = start_i && lookup_valid_i && hit &&
                      !(upd_valid_i && upd_mispredict_i);
  assign upd_en     = start_i && upd_valid_i;

  // Global history: repair from the branch's snapshot, otherwise shift in
  // the prediction of each BTB hit that is actually fetched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr <= '0;
    end else if (repair) begin
      ghr <= HIST_BITS'({upd_hist_i, upd_taken_i});
    end else if (spec_shift) begin
      ghr <= HIST_BITS'({ghr, pred_taken_o});
    end
  end

  // Direction counters train on every resolved conditional branch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= WNT;
      end
    end else if (upd_en) begin
      bht[upd_gidx] <= sat_cnt_update(bht[upd_gidx], upd_taken_i);
    end
  end

  // BTB valid bits: only taken branches allocate, so not-taken never evicts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btb_valid <= '0;
    end else if (upd_en && upd_taken_i) begin
      btb_valid[upd_bidx] <= 1'b1;
    end
  end

  // BTB payload needs no reset because valid gates it; writes are held off
  // while reset is asserted so nothing lands during the reset window.
  always_ff @(posedge clk_i) begin
    if (rst_i && upd_en && upd_taken_i) begin
      btb_tag[upd_bidx]    <= upd_tag;
      btb_target[upd_bidx] <= upd_target_i;
    end
  end

  sat_counter32 u_stat_lookups (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (spec_shift),
    .count (stat_lookups_o)
  );

  sat_counter32 u_stat_mispredicts (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (repair),
    .count (stat_mispredicts_o)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic,
// all compared against an array-based model of the prediction rules.
module tb_branch_predictor;

  localparam int ENT = 64;
  localparam int HB  = 6;
  localparam int TB  = 8;
  localparam int IDX = 6;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        start = 1'b0, lv = 1'b0, uv = 1'b0, ut = 1'b0, um = 1'b0;
  logic [31:0] pc = '0, upc = '0, utgt = '0;
  logic [5:0]  uh = '0;
  logic        pt;
  logic [31:0] ptgt, sl, sm;
  logic [5:0]  ghr;

  branch_predictor dut (
    .clk_i (clk), .rst_i (rst_n), .start_i (start), .lookup_valid_i (lv),
    .pc_i (pc), .pred_taken_o (pt), .pred_target_o (ptgt), .ghr_o (ghr),
    .upd_valid_i (uv), .upd_pc_i (upc), .upd_taken_i (ut),
    .upd_target_i (utgt), .upd_hist_i (uh), .upd_mispredict_i (um),
    .stat_lookups_o (sl), .stat_mispredicts_o (sm)
  );

  // Small instance for index/tag aliasing
  logic        s_start = 1'b0, s_lv = 1'b0, s_uv = 1'b0, s_ut = 1'b0, s_um = 1'b0;
  logic [31:0] s_pc = '0, s_upc = '0, s_utgt = '0;
  logic [3:0]  s_uh = '0;
  logic        s_pt;
  logic [31:0] s_ptgt, s_sl, s_sm;
  logic [3:0]  s_ghr;

  branch_predictor #(.ENTRIES(16), .HIST_BITS(4), .TAG_BITS(4)) dut_small (
    .clk_i (clk), .rst_i (rst_n), .start_i (s_start), .lookup_valid_i (s_lv),
    .pc_i (s_pc), .pred_taken_o (s_pt), .pred_target_o (s_ptgt), .ghr_o (s_ghr),
    .upd_valid_i (s_uv), .upd_pc_i (s_upc), .upd_taken_i (s_ut),
    .upd_target_i (s_utgt), .upd_hist_i (s_uh), .upd_mispredict_i (s_um),
    .stat_lookups_o (s_sl), .stat_mispredicts_o (s_sm)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed by integer arithmetic on the PC
  int          m_bht [ENT];
  bit          m_v   [ENT];
  int          m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ghr;
  longint      m_look, m_misp;

  function automatic int m_bidx(input logic [31:0] a);
    return int'(a / 4) % ENT;
  endfunction

  function automatic int m_tagof(input logic [31:0] a);
    return int'(a / (4 * ENT)) % (1 << TB);
  endfunction

  function automatic int m_gidx(input logic [31:0] a, input int h);
    return (m_bidx(a) ^ (h * (1 << (IDX - HB)))) % ENT;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_v[m_bidx(a)] && (m_tag[m_bidx(a)] == m_tagof(a));
  endfunction

  function automatic bit m_taken(input logic [31:0] a);
    return m_hit(a) && (m_bht[m_gidx(a, m_ghr)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] a);
    return m_taken(a) ? m_tgt[m_bidx(a)] : a + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_bht[i] = 1;
      m_v[i]   = 0;
      m_tag[i] = 0;
      m_tgt[i] = '0;
    end
    m_ghr  = 0;
    m_look = 0;
    m_misp = 0;
  endtask

  // Apply one clock edge worth of the rules to the model, using the inputs
  // currently driven on the big instance.
  task automatic m_step();
    bit spec, ptk, valid_misp;
    int g, b;
    if (!rst_n || !start) return;
    ptk        = m_taken(pc);
    valid_misp = uv && um;
    spec       = lv && m_hit(pc) && !valid_misp;
    if (uv) begin
      g = m_gidx(upc, int'(uh));
      if (ut) m_bht[g] = (m_bht[g] == 3) ? 3 : m_bht[g] + 1;
      else    m_bht[g] = (m_bht[g] == 0) ? 0 : m_bht[g] - 1;
      if (ut) begin
        b        = m_bidx(upc);
        m_v[b]   = 1;
        m_tag[b] = m_tagof(upc);
        m_tgt[b] = utgt;
      end
    end
    if (valid_misp)  m_ghr = (int'(uh) * 2 + int'(ut)) % (1 << HB);
    else if (spec)   m_ghr = (m_ghr * 2 + int'(ptk)) % (1 << HB);
    if (spec && m_look < 64'hFFFF_FFFF)      m_look++;
    if (valid_misp && m_misp < 64'hFFFF_FFFF) m_misp++;
  endtask

  // Driver: one clock edge, model follows, then settle just past the edge
  task automatic advance();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic clear_upd();
    uv = 1'b0; um = 1'b0; ut = 1'b0; upc = '0; utgt = '0; uh = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; lv = 1'b0; clear_upd();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; pc = 32'h40; lv = 1'b1;
    #1;
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", pt); end
    checks++; if (ptgt !== 32'h44) begin errors++; $display("FAIL reset_target got %h exp 00000044", ptgt); end
    checks++; if (ghr !== 6'd0) begin errors++; $display("FAIL reset_ghr got %h exp 00", ghr); end
    checks++; if (sl !== 32'd0 || sm !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", sl, sm); end
    advance();
    lv = 1'b0;
  endtask

  task automatic test_train();
    for (int i = 0; i < 3; i++) begin
      uv = 1'b1; upc = 32'h100; ut = 1'b1; utgt = 32'h80; uh = '0; um = (i == 0);
      advance();
    end
    clear_upd();
    #2;
    checks++; if (sm !== 32'd1) begin errors++; $display("FAIL train_mispredicts got %0d exp 1", sm); end
    checks++; if (ghr !== HB'(m_ghr)) begin errors++; $display("FAIL train_ghr got %h exp %h", ghr, HB'(m_ghr)); end
    // Repair history back to zero via a mispredict on an unrelated branch
    uv = 1'b1; upc = 32'h3F0; ut = 1'b0; uh = '0; um = 1'b1;
    advance();
    clear_upd();
    pc = 32'h100;
    #2;
    checks++; if (ghr !== 6'd0) begin errors++; $display("FAIL train_ghr_redrive got %h exp 00", ghr); end
    checks++; if (pt !== 1'b1) begin errors++; $display("FAIL train_taken got %b exp 1", pt); end
    checks++; if (ptgt !== 32'h80) begin errors++; $display("FAIL train_target got %h exp 00000080", ptgt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      uv = 1'b1; upc = 32'h180; ut = (i < 4); utgt = 32'h1C0; uh = '0; um = 1'b0;
      advance();
    end
    clear_upd();
    pc = 32'h180;
    #2;
    checks++; if (pt !== 1'b1 || ptgt !== 32'h1C0) begin errors++; $display("FAIL sat_after_one_nt got %b/%h exp 1/000001c0", pt, ptgt); end
    uv = 1'b1; upc = 32'h180; ut = 1'b0;
    advance();
    clear_upd();
    #2;
    checks++; if (pt !== 1'b0 || ptgt !== 32'h184) begin errors++; $display("FAIL sat_after_two_nt got %b/%h exp 0/00000184", pt, ptgt); end
  endtask

  task automatic test_collision();
    // Allocate the BTB entry while training a different counter
    uv = 1'b1; upc = 32'h2A0; ut = 1'b1; utgt = 32'h300; uh = 6'h3F; um = 1'b0;
    advance();
    // Lookup and update of the same counter in one cycle
    uh = '0; lv = 1'b1; pc = 32'h2A0;
    #2;
    checks++; if (pt !== 1'b0 || ptgt !== 32'h2A4) begin errors++; $display("FAIL collision_same_cycle got %b/%h exp 0/000002a4", pt, ptgt); end
    advance();
    clear_upd();
    #2;
    checks++; if (pt !== 1'b1 || ptgt !== 32'h300) begin errors++; $display("FAIL collision_next_cycle got %b/%h exp 1/00000300", pt, ptgt); end
    advance();
    lv = 1'b0;
  endtask

  task automatic test_repair();
    lv = 1'b1; pc = 32'h2A0;
    uv = 1'b1; upc = 32'h3F0; ut = 1'b0; uh = 6'b101010; um = 1'b1;
    advance();
    clear_upd(); lv = 1'b0;
    #2;
    checks++; if (ghr !== 6'b010100) begin errors++; $display("FAIL repair_ghr got %b exp 010100", ghr); end
    checks++; if (sm !== m_misp[31:0] || sl !== m_look[31:0]) begin errors++; $display("FAIL repair_stats got %0d/%0d exp %0d/%0d", sl, sm, m_look, m_misp); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    pool[0] = 32'h100; pool[1] = 32'h180; pool[2] = 32'h2A0; pool[3] = 32'h3F0;
    pool[4] = 32'h1000_0500; pool[5] = 32'hFFFF_FFFC; pool[6] = 32'h44; pool[7] = 32'h2A4;
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 9) != 0);
      lv    = 1'($urandom_range(0, 1));
      pc    = pool[$urandom_range(0, 7)];
      uv    = 1'($urandom_range(0, 1));
      upc   = pool[$urandom_range(0, 7)];
      ut    = 1'($urandom_range(0, 1));
      utgt  = $urandom() & 32'hFFFF_FFFC;
      uh    = 6'($urandom_range(0, 63));
      um    = ($urandom_range(0, 3) == 0);
      #2;
      checks++;
      if (pt !== m_taken(pc) || ptgt !== m_target(pc) || ghr !== HB'(m_ghr) ||
          sl !== m_look[31:0] || sm !== m_misp[31:0]) begin
        errors++;
        $display("FAIL random_cycle%0d pc %h got %b/%h/%h/%0d/%0d exp %b/%h/%h/%0d/%0d",
                 n, pc, pt, ptgt, ghr, sl, sm, m_taken(pc), m_target(pc),
                 HB'(m_ghr), m_look, m_misp);
      end
      advance();
    end
    start = 1'b1; lv = 1'b0; clear_upd();
  endtask

  task automatic test_reset_mid();
    lv = 1'b1; pc = 32'h100; uv = 1'b1; upc = 32'h100; ut = 1'b1; utgt = 32'h500; um = 1'b1;
    rst_n = 1'b0;
    m_reset();
    #2;
    checks++; if (pt !== 1'b0 || ptgt !== 32'h104 || ghr !== 6'd0) begin errors++; $display("FAIL midreset_async got %b/%h/%h exp 0/00000104/00", pt, ptgt, ghr); end
    checks++; if (sl !== 32'd0 || sm !== 32'd0) begin errors++; $display("FAIL midreset_stats got %0d/%0d exp 0/0", sl, sm); end
    advance();
    @(negedge clk);
    rst_n = 1'b1; clear_upd(); lv = 1'b0;
    #1;
    checks++; if (pt !== 1'b0 || ptgt !== 32'h104 || ghr !== 6'd0) begin errors++; $display("FAIL midreset_after got %b/%h/%h exp 0/00000104/00", pt, ptgt, ghr); end
    advance();
  endtask

  task automatic test_small_alias();
    start = 1'b0; s_start = 1'b1; s_lv = 1'b0;
    s_uv = 1'b1; s_upc = 32'h100; s_ut = 1'b1; s_utgt = 32'hA0; s_uh = '0; s_um = 1'b0;
    @(posedge clk); #1;
    s_upc = 32'h140; s_utgt = 32'hB0;
    @(posedge clk); #1;
    s_uv = 1'b0; s_pc = 32'h100;
    #2;
    checks++; if (s_pt !== 1'b0 || s_ptgt !== 32'h104) begin errors++; $display("FAIL small_evicted got %b/%h exp 0/00000104", s_pt, s_ptgt); end
    s_pc = 32'h140;
    #1;
    checks++; if (s_pt !== 1'b1 || s_ptgt !== 32'hB0) begin errors++; $display("FAIL small_replacer got %b/%h exp 1/000000b0", s_pt, s_ptgt); end
    s_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (s_pt !== 1'b0 || s_ptgt !== 32'h0) begin errors++; $display("FAIL small_wrap got %b/%h exp 0/00000000", s_pt, s_ptgt); end
    checks++; if (s_ghr !== 4'd0 || s_sl !== 32'd0) begin errors++; $display("FAIL small_ghr_stats got %h/%0d exp 0/0", s_ghr, s_sl); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_collision();
    test_repair();
    test_random();
    test_reset_mid();
    test_small_alias();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
